id_branch_stage: RTL

- Decode-side partner of the fetch stage.
- Captures the fetched pc_4/instruction pair into an IF/ID pipeline register.
- Resolves beq/bne/j/jal/jr in ID and drives the redirect pair (branchEnable/branchAddr) back to fetch.
- Stalls fetch when branch operands are not yet available, and squashes the wrong-path instruction after a taken redirect. Architecture has no delay slot.

---
 rtl/id_branch_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/id_branch_stage.sv
// ID stage with early branch resolution: holds the IF/ID register, resolves beq/bne/j/jal/jr,
// drives the fetch redirect, stalls on missing operands and squashes the wrong-path fetch.
module id_branch_stage #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clock,
    input  logic             cpu_rst,
    input  logic             cpu_en,
    input  logic [31:0]      if_pc_4,
    input  logic [31:0]      if_instruction,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             operand_ready,
    output logic             branchEnable,
    output logic [31:0]      branchAddr,
    output logic             stall,
    output logic [31:0]      id_pc_4,
    output logic [31:0]      id_instruction,
    output logic             id_valid,
    output logic             link_en,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StRun, StWait, StSquash} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_4_q, pc_4_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_beq, is_bne, is_j, is_jal, is_jr;
    logic        is_ctrl, needs_ops, taken, active;
    logic [31:0] target;

    assign op     = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign active = cpu_en & ~cpu_rst;

    always_comb begin
        is_beq    = valid_q & (op == 6'b000100);
        is_bne    = valid_q & (op == 6'b000101);
        is_j      = valid_q & (op == 6'b000010);
        is_jal    = valid_q & (op == 6'b000011);
        is_jr     = valid_q & (op == 6'b000000) & (funct == 6'b001000);
        is_ctrl   = is_beq | is_bne | is_j | is_jal | is_jr;
        needs_ops = is_beq | is_bne | is_jr;

        taken = 1'b0;
        if (is_beq) begin
            taken = (rs_data == rt_data);
        end else if (is_bne) begin
            taken = (rs_data != rt_data);
        end else if (is_j | is_jal | is_jr) begin
            taken = 1'b1;
        end

        if (is_jr) begin
            target = rs_data;
        end else if (is_j | is_jal) begin
            target = {pc_4_q[31:28], instr_q[25:0], 2'b00};
        end else begin
            target = pc_4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end

        stall        = active & needs_ops & ~operand_ready;
        branchEnable = active & taken & ~stall;
        branchAddr   = branchEnable ? target : 32'h0;
        link_en      = active & is_jal;
    end

    // Next state for FSM, IF/ID and counters; cpu_en=0 leaves every default (hold) in place.
    always_comb begin
        state_d      = state_q;
        pc_4_d       = pc_4_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        stall_cnt_d  = stall_cnt_q;

        if (cpu_en) begin
            unique case (state_q)
                StRun: begin
                    if (branchEnable) begin
                        state_d = StSquash;
                    end else if (stall) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (branchEnable) begin
                        state_d = StSquash;
                    end else if (operand_ready & ~taken) begin
                        state_d = StRun;
                    end
                end
                StSquash: state_d = StRun;
                default:  state_d = StRun;
            endcase

            if (branchEnable) begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                pc_4_d  = if_pc_4;
            end else if (!stall) begin
                instr_d = if_instruction;
                valid_d = 1'b1;
                pc_4_d  = if_pc_4;
            end

            if (is_ctrl & ~stall) begin
                branch_cnt_d = branch_cnt_q + 1'b1;
            end
            if (branchEnable) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
            if (stall) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            state_q      <= StRun;
            pc_4_q       <= 32'h0;
            instr_q      <= NOP_WORD;
            valid_q      <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_4_q       <= pc_4_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_pc_4        = pc_4_q;
    assign id_instruction = instr_q;
    assign id_valid       = valid_q;
    assign link_addr      = pc_4_q;
    assign branch_count   = branch_cnt_q;
    assign taken_count    = taken_cnt_q;
    assign stall_count    = stall_cnt_q;

endmodule
